// File: rtl/spi_target.sv
// SPI mode-0 target clocked entirely from the system clock: the pins are synchronized and
// their edges are detected in clk, with one-word TX holding and RX output registers.
module spi_target #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              tx_underrun_o,
    output logic              rx_overrun_o,
    output logic              busy_o
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_s, cs_s, mosi_s, sck_q, cs_q;
    logic                   sck_rise, sck_fall, cs_fall;
    state_t                 state, state_nxt;
    logic                   start, load, shift_en, wrap, rx_take, reload_pend;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_W-1:0]      rx_sr, rx_word, tx_sr, hold_data;
    logic                   hold_full;

    // Synchronizers reset to the bus idle levels so no spurious edge is seen at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sck_q     <= sck_s;
            cs_q      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: if (cs_fall) begin
                state_nxt = SHIFT;
                start     = 1'b1;
                load      = 1'b1;
            end
            SHIFT: begin
                if (cs_s) state_nxt = IDLE;
                else if (sck_fall && reload_pend) load = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A CS rise takes priority over any SCK edge seen in the same cycle.
    assign shift_en = (state == SHIFT) && !cs_s;
    assign rx_word  = {rx_sr[DATA_W-2:0], mosi_s};
    assign wrap     = shift_en && sck_rise && (cnt == CNT_W'(DATA_W-1));
    assign rx_take  = wrap && (!rx_valid_o || rx_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            rx_sr         <= '0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            rx_overrun_o  <= 1'b0;
            tx_sr         <= '0;
            tx_underrun_o <= 1'b0;
            reload_pend   <= 1'b0;
            hold_full     <= 1'b0;
            hold_data     <= '0;
        end else begin
            tx_underrun_o <= load && !hold_full;
            rx_overrun_o  <= wrap && !rx_take;

            if (start) begin
                cnt <= '0;
            end else if (shift_en && sck_rise) begin
                rx_sr <= rx_word;
                cnt   <= wrap ? '0 : cnt + 1'b1;
            end

            if (rx_take) begin
                rx_data_o  <= rx_word;
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if (load)                      tx_sr <= hold_full ? hold_data : '0;
            else if (shift_en && sck_fall) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};

            if (state_nxt == IDLE || start) reload_pend <= 1'b0;
            else if (wrap)                  reload_pend <= 1'b1;
            else if (load)                  reload_pend <= 1'b0;

            // Accept only fires while empty, so it never feeds a load in the same cycle.
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_valid_i && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data_i;
            end
        end
    end

    assign spi_miso_oe_o = (state == SHIFT);
    assign busy_o        = (state == SHIFT);
    assign spi_miso_o    = (state == SHIFT) && tx_sr[DATA_W-1];
    assign tx_ready_o    = !hold_full;
endmodule
